// File: rtl/izh_neuron_array.sv
// Time-multiplexed Izhikevich neuron engine: one neuron per cycle through a
// 2-stage fixed-point pipeline, with v/u state held in internal arrays.
module izh_neuron_array #(
  parameter int NUM_NEURONS = 8,
  parameter int WIDTH       = 17,
  parameter int FRAC        = 8,
  parameter int DT_SHIFT    = 0,
  parameter int A_K         = 5,
  parameter int B_K         = 51,
  parameter int C_K         = -16640,
  parameter int D_K         = 2048,
  parameter int VPEAK_K     = 7680
) (
  input  logic                             clk,
  input  logic                             asyn_reset,
  input  logic                             start,
  input  logic [NUM_NEURONS*WIDTH-1:0]     i_bus,
  output logic                             busy,
  output logic                             done,
  output logic [NUM_NEURONS-1:0]           spikes_out,
  input  logic [$clog2(NUM_NEURONS)-1:0]   rd_idx,
  output logic [WIDTH-1:0]                 rd_v,
  output logic [WIDTH-1:0]                 rd_u,
  output logic [15:0]                      sweep_count
);

  localparam int unsigned IDXW = $clog2(NUM_NEURONS);
  localparam int unsigned IW   = 2*WIDTH + 8;

  typedef logic signed [IW-1:0]    wide_t;
  typedef logic signed [WIDTH-1:0] word_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam wide_t SAT_MAX = (wide_t'(1) <<< (WIDTH-1)) - wide_t'(1);
  localparam wide_t SAT_MIN = -(wide_t'(1) <<< (WIDTH-1));
  localparam word_t V_RST   = word_t'(C_K);
  localparam word_t U_RST   = word_t'((wide_t'(B_K) * wide_t'(C_K)) >>> FRAC);

  function automatic word_t sat(input wide_t x);
    if (x > SAT_MAX)      sat = word_t'(SAT_MAX);
    else if (x < SAT_MIN) sat = word_t'(SAT_MIN);
    else                  sat = word_t'(x);
  endfunction

  state_t                 state, state_nxt;
  logic [IDXW-1:0]        idx;
  logic [NUM_NEURONS*WIDTH-1:0] i_lat;
  word_t                  v_arr [NUM_NEURONS];
  word_t                  u_arr [NUM_NEURONS];
  logic                   accept_c, issue_c;

  logic                   s1_valid;
  logic [IDXW-1:0]        s1_idx;
  wide_t                  s1_v, s1_u, s1_sq, s1_lin, s1_bv;

  word_t                  v_cur_c, u_cur_c, i_cur_c;
  wide_t                  sq_c, lin_c, bv_c;
  wide_t                  dv_c, du_c, vn_w_c, un_w_c;
  word_t                  vn_c, un_c, u_spk_c;
  logic                   fire_c;

  // FSM state register
  always_ff @(posedge clk) begin
    if (asyn_reset) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (idx == IDXW'(NUM_NEURONS-1)) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM control strobes
  always_comb begin
    accept_c = 1'b0;
    issue_c  = 1'b0;
    case (state)
      S_IDLE:  accept_c = start;
      S_RUN:   issue_c  = 1'b1;
      default: ;
    endcase
  end

  // Stage 1: operand fetch and first-level products
  always_comb begin
    v_cur_c = v_arr[idx];
    u_cur_c = u_arr[idx];
    i_cur_c = word_t'(i_lat[idx*WIDTH +: WIDTH]);
    sq_c    = (wide_t'(10) * wide_t'(v_cur_c) * wide_t'(v_cur_c)) >>> (2*FRAC);
    lin_c   = wide_t'(5) * wide_t'(v_cur_c) + (wide_t'(140) <<< FRAC)
              - wide_t'(u_cur_c) + wide_t'(i_cur_c);
    bv_c    = (wide_t'(B_K) * wide_t'(v_cur_c)) >>> FRAC;
  end

  // Stage 2: integrate, saturate, detect spike
  always_comb begin
    dv_c    = s1_sq + s1_lin;
    vn_w_c  = s1_v + (dv_c >>> DT_SHIFT);
    du_c    = (wide_t'(A_K) * (s1_bv - s1_u)) >>> FRAC;
    un_w_c  = s1_u + (du_c >>> DT_SHIFT);
    vn_c    = sat(vn_w_c);
    un_c    = sat(un_w_c);
    fire_c  = wide_t'(vn_c) >= wide_t'(VPEAK_K);
    u_spk_c = sat(wide_t'(un_c) + wide_t'(D_K));
  end

  // Sweep index, current latch and stage-1 pipeline register
  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      idx      <= '0;
      i_lat    <= '0;
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_v     <= '0;
      s1_u     <= '0;
      s1_sq    <= '0;
      s1_lin   <= '0;
      s1_bv    <= '0;
    end else begin
      s1_valid <= issue_c;
      if (accept_c) begin
        idx   <= '0;
        i_lat <= i_bus;
      end else if (issue_c) begin
        idx <= idx + IDXW'(1);
      end
      if (issue_c) begin
        s1_idx <= idx;
        s1_v   <= wide_t'(v_cur_c);
        s1_u   <= wide_t'(u_cur_c);
        s1_sq  <= sq_c;
        s1_lin <= lin_c;
        s1_bv  <= bv_c;
      end
    end
  end

  // State arrays, spike vector and write-back
  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        v_arr[k] <= V_RST;
        u_arr[k] <= U_RST;
      end
      spikes_out <= '0;
    end else begin
      if (accept_c) spikes_out <= '0;
      if (s1_valid) begin
        if (fire_c) begin
          v_arr[s1_idx]      <= V_RST;
          u_arr[s1_idx]      <= u_spk_c;
          spikes_out[s1_idx] <= 1'b1;
        end else begin
          v_arr[s1_idx] <= vn_c;
          u_arr[s1_idx] <= un_c;
        end
      end
    end
  end

  // Registered status outputs and read port
  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      sweep_count <= '0;
      rd_v        <= '0;
      rd_u        <= '0;
    end else begin
      busy <= (state_nxt != S_IDLE);
      done <= (state_nxt == S_DONE);
      if (state_nxt == S_DONE) sweep_count <= sweep_count + 16'd1;
      rd_v <= v_arr[rd_idx];
      rd_u <= u_arr[rd_idx];
    end
  end

endmodule

// File: tb/tb_izh_neuron_array.sv
// Self-checking bench for izh_neuron_array against a plain-arithmetic
// neuron model with randomized input currents.
module tb_izh_neuron_array;

  localparam int N     = 8;
  localparam int W     = 17;
  localparam int FRAC  = 8;
  localparam int DT    = 0;
  localparam int A_K   = 5;
  localparam int B_K   = 51;
  localparam int C_K   = -16640;
  localparam int D_K   = 2048;
  localparam int VPEAK = 7680;
  localparam int U_RST = -3315;

  logic                 clk = 1'b0;
  logic                 asyn_reset = 1'b1;
  logic                 start = 1'b0;
  logic [N*W-1:0]       i_bus = '0;
  logic                 busy, done;
  logic [N-1:0]         spikes_out;
  logic [$clog2(N)-1:0] rd_idx = '0;
  logic [W-1:0]         rd_v, rd_u;
  logic [15:0]          sweep_count;

  int n_tests = 0;
  int n_fail  = 0;

  int       mv [N];
  int       mu [N];
  int       cur [N];
  logic [N-1:0] exp_spk;
  int       exp_count = 0;

  always #5 clk = ~clk;

  izh_neuron_array dut (
    .clk(clk), .asyn_reset(asyn_reset), .start(start), .i_bus(i_bus),
    .busy(busy), .done(done), .spikes_out(spikes_out), .rd_idx(rd_idx),
    .rd_v(rd_v), .rd_u(rd_u), .sweep_count(sweep_count)
  );

  function automatic longint sat(input longint x);
    longint hi = (longint'(1) <<< (W-1)) - 1;
    longint lo = -(longint'(1) <<< (W-1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Reference: one full tick of the Izhikevich update for every neuron
  task automatic model_sweep();
    exp_spk = '0;
    for (int k = 0; k < N; k++) begin
      longint lv = mv[k];
      longint lu = mu[k];
      longint li = cur[k];
      longint sq  = (10 * lv * lv) >>> (2*FRAC);
      longint lin = 5 * lv + (140 <<< FRAC) - lu + li;
      longint bv  = (B_K * lv) >>> FRAC;
      longint vn  = sat(lv + ((sq + lin) >>> DT));
      longint un  = sat(lu + (((A_K * (bv - lu)) >>> FRAC) >>> DT));
      if (vn >= VPEAK) begin
        mv[k] = C_K;
        mu[k] = int'(sat(un + D_K));
        exp_spk[k] = 1'b1;
      end else begin
        mv[k] = int'(vn);
        mu[k] = int'(un);
      end
    end
    exp_count = (exp_count + 1) % 65536;
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = C_K;
      mu[k] = U_RST;
    end
    exp_count = 0;
  endtask

  task automatic drive_currents();
    for (int k = 0; k < N; k++) i_bus[k*W +: W] = W'(cur[k]);
  endtask

  task automatic pulse_reset();
    asyn_reset = 1'b1;
    repeat (2) @(negedge clk);
    asyn_reset = 1'b0;
    model_reset();
  endtask

  // Drive start for one cycle and wait (bounded) for done; cycle 0 = accept cycle
  task automatic run_sweep(output int dcyc, output logic [N-1:0] spk);
    dcyc = -1;
    spk  = '0;
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (done === 1'b1) begin
        dcyc = c;
        spk  = spikes_out;
        break;
      end
    end
  endtask

  task automatic read_state(input int k, output logic [W-1:0] v, output logic [W-1:0] u);
    rd_idx = ($clog2(N))'(k);
    @(negedge clk);
    v = rd_v;
    u = rd_u;
  endtask

  task automatic test_reset();
    logic [W-1:0] v, u;
    pulse_reset();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || spikes_out !== '0 || sweep_count !== 16'd0
        || rd_v !== '0 || rd_u !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b spk=%h cnt=%0d rd_v=%0d rd_u=%0d, want all zero",
               busy, done, spikes_out, sweep_count, $signed(rd_v), $signed(rd_u));
    end
    for (int k = 0; k < N; k++) begin
      read_state(k, v, u);
      n_tests++;
      if (v !== W'(C_K) || u !== W'(U_RST)) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: v=%0d u=%0d, want v=%0d u=%0d",
                 k, $signed(v), $signed(u), C_K, U_RST);
      end
    end
  endtask

  task automatic test_zero_sweep();
    int dcyc;
    logic [N-1:0] spk;
    logic [W-1:0] v, u;
    for (int k = 0; k < N; k++) cur[k] = 0;
    drive_currents();
    run_sweep(dcyc, spk);
    model_sweep();
    n_tests++;
    if (dcyc != N + 2 || spk !== 8'h00 || sweep_count !== 16'd1) begin
      n_fail++;
      $display("FAIL zero_sweep: done_cycle=%0d spk=%h cnt=%0d, want %0d 00 1",
               dcyc, spk, sweep_count, N + 2);
    end
    for (int k = 0; k < N; k++) begin
      read_state(k, v, u);
      n_tests++;
      if (v !== W'(-18435) || u !== W'(-3315) || v !== W'(mv[k]) || u !== W'(mu[k])) begin
        n_fail++;
        $display("FAIL zero_state[%0d]: v=%0d u=%0d, want v=-18435 u=-3315",
                 k, $signed(v), $signed(u));
      end
    end
  endtask

  task automatic test_sat_drive();
    int dcyc;
    logic [N-1:0] spk;
    logic [W-1:0] v, u;
    pulse_reset();
    for (int k = 0; k < N; k++) cur[k] = (k == 3) ? 32'h0FFFF : 0;
    drive_currents();
    run_sweep(dcyc, spk);
    model_sweep();
    n_tests++;
    if (dcyc != N + 2 || spk !== 8'h08 || spk !== exp_spk) begin
      n_fail++;
      $display("FAIL sat_drive_spikes: done_cycle=%0d spk=%h, want %0d 08", dcyc, spk, N + 2);
    end
    read_state(3, v, u);
    n_tests++;
    if (v !== W'(-16640) || u !== W'(-1267)) begin
      n_fail++;
      $display("FAIL sat_drive_n3: v=%0d u=%0d, want v=-16640 u=-1267", $signed(v), $signed(u));
    end
    for (int k = 0; k < N; k++) begin
      read_state(k, v, u);
      n_tests++;
      if (v !== W'(mv[k]) || u !== W'(mu[k])) begin
        n_fail++;
        $display("FAIL sat_drive_state[%0d]: v=%0d u=%0d, want v=%0d u=%0d",
                 k, $signed(v), $signed(u), mv[k], mu[k]);
      end
    end
  endtask

  task automatic test_random();
    int dcyc;
    logic [N-1:0] spk;
    logic [W-1:0] v, u;
    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < N; k++) cur[k] = int'($urandom_range(0, 28000)) - 6000;
      drive_currents();
      run_sweep(dcyc, spk);
      model_sweep();
      n_tests++;
      if (dcyc != N + 2 || spk !== exp_spk || sweep_count !== 16'(exp_count)) begin
        n_fail++;
        $display("FAIL random_sweep%0d: done_cycle=%0d spk=%h cnt=%0d, want %0d %h %0d",
                 s, dcyc, spk, sweep_count, N + 2, exp_spk, exp_count);
      end
      for (int k = 0; k < N; k++) begin
        read_state(k, v, u);
        n_tests++;
        if (v !== W'(mv[k]) || u !== W'(mu[k])) begin
          n_fail++;
          $display("FAIL random_state%0d[%0d]: v=%0d u=%0d, want v=%0d u=%0d",
                   s, k, $signed(v), $signed(u), mv[k], mu[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int dcycs [$];
    logic [N-1:0] last_spk = '0;
    logic [W-1:0] v, u;
    for (int k = 0; k < N; k++) cur[k] = int'($urandom_range(0, 12000));
    drive_currents();
    start = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 30) start = 1'b0;
      if (done === 1'b1) begin
        dcycs.push_back(c);
        last_spk = spikes_out;
      end
    end
    for (int s = 0; s < 3; s++) model_sweep();
    n_tests++;
    if (dcycs.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_count: dones=%0d, want 3", dcycs.size());
    end else begin
      n_tests++;
      if (dcycs[0] != 10 || dcycs[1] != 21 || dcycs[2] != 32) begin
        n_fail++;
        $display("FAIL b2b_cycles: %0d %0d %0d, want 10 21 32", dcycs[0], dcycs[1], dcycs[2]);
      end
    end
    n_tests++;
    if (sweep_count !== 16'(exp_count) || last_spk !== exp_spk) begin
      n_fail++;
      $display("FAIL b2b_totals: cnt=%0d spk=%h, want %0d %h", sweep_count, last_spk, exp_count, exp_spk);
    end
    for (int k = 0; k < N; k++) begin
      read_state(k, v, u);
      n_tests++;
      if (v !== W'(mv[k]) || u !== W'(mu[k])) begin
        n_fail++;
        $display("FAIL b2b_state[%0d]: v=%0d u=%0d, want v=%0d u=%0d",
                 k, $signed(v), $signed(u), mv[k], mu[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int saw_done = 0;
    logic [W-1:0] v, u;
    for (int k = 0; k < N; k++) cur[k] = 20000;
    drive_currents();
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 5) asyn_reset = 1'b1;
      if (c == 6) begin
        asyn_reset = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_mid_busy: busy=%b, want 0", busy);
        end
      end
      if (done === 1'b1) saw_done++;
    end
    model_reset();
    n_tests++;
    if (saw_done != 0 || sweep_count !== 16'd0 || spikes_out !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_status: dones=%0d cnt=%0d spk=%h, want 0 0 00",
               saw_done, sweep_count, spikes_out);
    end
    for (int k = 0; k < N; k++) begin
      read_state(k, v, u);
      n_tests++;
      if (v !== W'(C_K) || u !== W'(U_RST)) begin
        n_fail++;
        $display("FAIL reset_mid_state[%0d]: v=%0d u=%0d, want v=%0d u=%0d",
                 k, $signed(v), $signed(u), C_K, U_RST);
      end
    end
  endtask

  task automatic test_wrap();
    int dcyc;
    logic [N-1:0] spk;
    force dut.sweep_count = 16'hFFFF;
    @(negedge clk);
    release dut.sweep_count;
    @(negedge clk);
    for (int k = 0; k < N; k++) cur[k] = 0;
    drive_currents();
    run_sweep(dcyc, spk);
    n_tests++;
    if (dcyc != N + 2 || sweep_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap: done_cycle=%0d cnt=%h, want %0d 0000", dcyc, sweep_count, N + 2);
    end
  endtask

  initial begin
    test_reset();
    test_zero_sweep();
    test_sat_drive();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
